// File: rtl/rr_arb_wgt.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb_wgt
// Description : Weighted round-robin arbiter. It holds a registered one-hot
//               grant until acknowledge, and each channel keeps the grant for
//               up to its weight in consecutive transfers.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb_wgt #(
    parameter int REQCNT   = 5,
    parameter int REQWIDTH = $clog2(REQCNT),
    parameter int WGTWIDTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic [REQCNT-1:0]          req_i,
    input  logic [REQCNT*WGTWIDTH-1:0] weight_i,
    input  logic                       gnt_ack_i,
    output logic [REQCNT-1:0]          gnt_o,
    output logic [REQWIDTH-1:0]        gnt_num_o,
    output logic                       gnt_val_o
);

    localparam logic [0:0]          c_ST_IDLE    = 1'b0;
    localparam logic [0:0]          c_ST_GRANT   = 1'b1;
    localparam logic [REQWIDTH:0]   c_REQCNT_W   = (REQWIDTH+1)'(REQCNT);
    localparam logic [REQWIDTH-1:0] c_LAST       = REQWIDTH'(REQCNT-1);
    localparam logic [WGTWIDTH-1:0] c_CREDIT_ONE = WGTWIDTH'(1);

    logic [0:0]          r_state,   w_state_nxt;
    logic [REQWIDTH-1:0] r_ptr,     w_ptr_nxt;
    logic [WGTWIDTH-1:0] r_credit,  w_credit_nxt;
    logic [REQWIDTH-1:0] r_gnt_num, w_gnt_num_nxt;
    logic                r_gnt_val, w_gnt_val_nxt;
    logic [REQCNT-1:0]   r_gnt,     w_gnt_nxt;

    logic [WGTWIDTH-1:0] w_wgt [REQCNT];
    logic [REQWIDTH-1:0] w_arb_base;
    logic                w_arb_mask_en;
    logic                w_arb_found;
    logic [REQWIDTH-1:0] w_arb_sel;
    logic [REQWIDTH:0]   w_sum;
    logic [REQWIDTH-1:0] w_idx;
    logic [WGTWIDTH-1:0] w_fresh_credit;
    logic [REQWIDTH-1:0] w_handoff_ptr;
    logic                w_cur_req;

    generate
        for (genvar k = 0; k < REQCNT; k++) begin : g_wgt
            assign w_wgt[k] = weight_i[k*WGTWIDTH +: WGTWIDTH];
        end
    endgenerate

    assign w_cur_req      = req_i[r_gnt_num];
    assign w_handoff_ptr  = (r_gnt_num == c_LAST) ? '0 : r_gnt_num + 1'b1;
    assign w_arb_base     = (r_state == c_ST_GRANT) ? w_handoff_ptr : r_ptr;
    assign w_arb_mask_en  = (r_state == c_ST_GRANT);
    assign w_fresh_credit = (w_wgt[w_arb_sel] == '0) ? c_CREDIT_ONE : w_wgt[w_arb_sel];

    // Circular first-set search; the wrap is explicit because REQCNT need not be a power of two.
    always_comb begin
        w_arb_found = 1'b0;
        w_arb_sel   = '0;
        w_sum       = '0;
        w_idx       = '0;
        for (int i = 0; i < REQCNT; i++) begin
            w_sum = {1'b0, w_arb_base} + (REQWIDTH+1)'(i);
            if (w_sum >= c_REQCNT_W) begin
                w_sum = w_sum - c_REQCNT_W;
            end
            w_idx = w_sum[REQWIDTH-1:0];
            if (!w_arb_found && req_i[w_idx] && !(w_arb_mask_en && (w_idx == r_gnt_num))) begin
                w_arb_found = 1'b1;
                w_arb_sel   = w_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_credit_nxt  = r_credit;
        w_gnt_num_nxt = r_gnt_num;
        w_gnt_val_nxt = r_gnt_val;
        if (r_state == c_ST_IDLE) begin
            if (w_arb_found) begin
                w_state_nxt   = c_ST_GRANT;
                w_gnt_num_nxt = w_arb_sel;
                w_gnt_val_nxt = 1'b1;
                w_credit_nxt  = w_fresh_credit;
            end
        end else begin
            if (gnt_ack_i && w_cur_req && (r_credit > c_CREDIT_ONE)) begin
                w_credit_nxt = r_credit - 1'b1;
            end else if (gnt_ack_i || !w_cur_req) begin
                // Credit exhausted or requester withdrew: rotate and hand off.
                w_ptr_nxt = w_handoff_ptr;
                if (w_arb_found) begin
                    w_gnt_num_nxt = w_arb_sel;
                    w_credit_nxt  = w_fresh_credit;
                end else begin
                    w_state_nxt   = c_ST_IDLE;
                    w_gnt_num_nxt = '0;
                    w_gnt_val_nxt = 1'b0;
                    w_credit_nxt  = '0;
                end
            end
        end
        w_gnt_nxt = w_gnt_val_nxt ? (REQCNT'(1) << w_gnt_num_nxt) : '0;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state   <= c_ST_IDLE;
            r_ptr     <= '0;
            r_credit  <= '0;
            r_gnt_num <= '0;
            r_gnt_val <= 1'b0;
            r_gnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_credit  <= w_credit_nxt;
            r_gnt_num <= w_gnt_num_nxt;
            r_gnt_val <= w_gnt_val_nxt;
            r_gnt     <= w_gnt_nxt;
        end
    end

    assign gnt_o     = r_gnt;
    assign gnt_num_o = r_gnt_num;
    assign gnt_val_o = r_gnt_val;

endmodule
`default_nettype wire
